// File: rtl/stroke_pkg.sv
// Shared types for the stroke rasterizer: FSM states, default widths, pixel point.
package stroke_pkg;
  localparam int X_W_DEF   = 11;
  localparam int Y_W_DEF   = 10;
  localparam int ERR_W_DEF = X_W_DEF + 2;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
  } point_t;
endpackage

// File: rtl/line_stepper.sv
// One combinational Bresenham step: advances (x,y,err) toward the line end.
module line_stepper #(
  parameter int W = 13
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] err,
  input  logic signed [W-1:0] dx,
  input  logic signed [W-1:0] dy,
  input  logic signed [W-1:0] sx,
  input  logic signed [W-1:0] sy,
  output logic signed [W-1:0] x_nxt,
  output logic signed [W-1:0] y_nxt,
  output logic signed [W-1:0] err_nxt
);
  logic signed [W:0] e2;
  logic              step_x, step_y;

  always_comb begin
    // e2 gets one extra bit so doubling err never overflows
    e2      = {err, 1'b0};
    step_x  = e2 >= $signed({dy[W-1], dy});
    step_y  = e2 <= $signed({dx[W-1], dx});
    x_nxt   = step_x ? x + sx : x;
    y_nxt   = step_y ? y + sy : y;
    err_nxt = err + (step_x ? dy : {W{1'b0}}) + (step_y ? dx : {W{1'b0}});
  end
endmodule

// File: rtl/stroke_rasterizer.sv
// Joins successive centre-of-mass points into Bresenham lines, streamed out as pixels.
module stroke_rasterizer
  import stroke_pkg::*;
#(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int MAX_JUMP = 128
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] x_com,
  input  logic [Y_W-1:0] y_com,
  input  logic           valid_com,
  input  logic           pen_down_in,
  output logic [X_W-1:0] pixel_x_out,
  output logic [Y_W-1:0] pixel_y_out,
  output logic           pixel_valid_out,
  input  logic           pixel_ready_in,
  output logic           busy_out,
  output logic           drop_out
);
  localparam int E_W = X_W + 2;
  localparam logic signed [E_W-1:0] P_ONE = E_W'(1);
  localparam logic signed [E_W-1:0] M_ONE = -E_W'(1);
  localparam logic signed [E_W-1:0] MAX_J = E_W'(MAX_JUMP);

  state_t state, state_nxt;

  logic           pend_full, anchor_vld;
  logic [X_W-1:0] pend_x, anc_x, end_x;
  logic [Y_W-1:0] pend_y, anc_y, end_y;

  logic signed [E_W-1:0] cur_x, cur_y, err, dx, dy, sx, sy;
  logic signed [E_W-1:0] nxt_x, nxt_y, nxt_err;
  logic signed [E_W-1:0] end_xs, end_ys, anc_xs, anc_ys;
  logic signed [E_W-1:0] dlt_x, dlt_y, abs_x, abs_y;

  logic cap, consume, xfer, at_end, jump;
  logic unused_hi;

  assign cap     = valid_com & pen_down_in;
  assign consume = (state == IDLE) & pend_full;
  assign xfer    = pixel_valid_out & pixel_ready_in;

  // coordinates are unsigned; zero-extend into the signed error-term width
  assign end_xs = $signed({2'b00, end_x});
  assign end_ys = $signed({{(E_W-Y_W){1'b0}}, end_y});
  assign anc_xs = $signed({2'b00, anc_x});
  assign anc_ys = $signed({{(E_W-Y_W){1'b0}}, anc_y});
  assign dlt_x  = end_xs - anc_xs;
  assign dlt_y  = end_ys - anc_ys;
  assign abs_x  = dlt_x[E_W-1] ? -dlt_x : dlt_x;
  assign abs_y  = dlt_y[E_W-1] ? -dlt_y : dlt_y;
  assign jump   = !anchor_vld || (abs_x > MAX_J) || (abs_y > MAX_J);
  assign at_end = (cur_x == end_xs) && (cur_y == end_ys);

  assign pixel_valid_out = (state == DRAW);
  assign pixel_x_out     = cur_x[X_W-1:0];
  assign pixel_y_out     = cur_y[Y_W-1:0];
  assign busy_out        = (state != IDLE) | pend_full;
  assign unused_hi       = ^{cur_x[E_W-1:X_W], cur_y[E_W-1:Y_W]};

  line_stepper #(.W(E_W)) u_step (
    .x(cur_x), .y(cur_y), .err(err), .dx(dx), .dy(dy), .sx(sx), .sy(sy),
    .x_nxt(nxt_x), .y_nxt(nxt_y), .err_nxt(nxt_err)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend_full) state_nxt = SETUP;
      SETUP:   state_nxt = DRAW;
      DRAW:    if (xfer && at_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      pend_full  <= 1'b0;
      anchor_vld <= 1'b0;
      drop_out   <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      anc_x      <= '0;
      anc_y      <= '0;
      end_x      <= '0;
      end_y      <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      err        <= '0;
      dx         <= '0;
      dy         <= '0;
      sx         <= P_ONE;
      sy         <= P_ONE;
    end else begin
      state <= state_nxt;
      // a capture in the same cycle IDLE empties pending is not a drop
      drop_out  <= cap & pend_full & ~consume;
      pend_full <= cap | (pend_full & ~consume);
      if (cap) begin
        pend_x <= x_com;
        pend_y <= y_com;
      end
      if (consume) begin
        end_x <= pend_x;
        end_y <= pend_y;
      end
      if (state == SETUP) begin
        if (jump) begin
          cur_x <= end_xs;
          cur_y <= end_ys;
          dx    <= '0;
          dy    <= '0;
          err   <= '0;
          sx    <= P_ONE;
          sy    <= P_ONE;
        end else begin
          cur_x <= anc_xs;
          cur_y <= anc_ys;
          dx    <= abs_x;
          dy    <= -abs_y;
          err   <= abs_x - abs_y;
          sx    <= dlt_x[E_W-1] ? M_ONE : P_ONE;
          sy    <= dlt_y[E_W-1] ? M_ONE : P_ONE;
        end
      end
      if (xfer) begin
        if (at_end) begin
          anc_x      <= end_x;
          anc_y      <= end_y;
          anchor_vld <= 1'b1;
        end else begin
          cur_x <= nxt_x;
          cur_y <= nxt_y;
          err   <= nxt_err;
        end
      end
      // pen lift breaks the stroke even if a line just completed
      if (!pen_down_in) anchor_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stroke_rasterizer.sv
// Scoreboard bench for stroke_rasterizer: expected pixels queued at stimulus time, observed pixels logged at transfer.
module tb_stroke_rasterizer;
  import stroke_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] x_com = '0;
  logic [9:0]  y_com = '0;
  logic        valid_com = 1'b0;
  logic        pen_down_in = 1'b0;
  logic        pixel_ready_in = 1'b1;
  logic [10:0] pixel_x_out;
  logic [9:0]  pixel_y_out;
  logic        pixel_valid_out, busy_out, drop_out;

  typedef struct {
    point_t p;
    int     c;
  } obs_t;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  point_t exp_q[$];
  obs_t   obs_q[$];

  stroke_rasterizer #(.X_W(11), .Y_W(10), .MAX_JUMP(128)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_com(x_com), .y_com(y_com),
    .valid_com(valid_com), .pen_down_in(pen_down_in),
    .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
    .pixel_valid_out(pixel_valid_out), .pixel_ready_in(pixel_ready_in),
    .busy_out(busy_out), .drop_out(drop_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    obs_t o;
    if (rst_in && pixel_valid_out && pixel_ready_in) begin
      o.p.x = pixel_x_out;
      o.p.y = pixel_y_out;
      o.c   = cyc;
      obs_q.push_back(o);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int x, input int y);
    x_com     = 11'(x);
    y_com     = 10'(y);
    valid_com = 1'b1;
    tick();
    valid_com = 1'b0;
  endtask

  task automatic expect_px(input int x, input int y);
    point_t p;
    p.x = 11'(x);
    p.y = 10'(y);
    exp_q.push_back(p);
  endtask

  // reference Bresenham walk from (x0,y0) to (x1,y1), endpoints included
  task automatic expect_line(input int x0, input int y0, input int x1, input int y1);
    int x, y, ddx, ddy, stx, sty, e, e2;
    x = x0; y = y0;
    ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ddy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    stx = (x0 < x1) ? 1 : -1;
    sty = (y0 < y1) ? 1 : -1;
    e = ddx + ddy;
    for (int k = 0; k < 4096; k++) begin
      expect_px(x, y);
      if (x == x1 && y == y1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; x += stx; end
      if (e2 <= ddx) begin e += ddx; y += sty; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!busy_out && !pixel_valid_out) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // forces a fresh stroke at (x,y) and discards its single pixel
  task automatic set_anchor(input int x, input int y);
    bit ok;
    pixel_ready_in = 1'b1;
    pen_down_in = 1'b0;
    tick();
    pen_down_in = 1'b1;
    send(x, y);
    wait_idle(ok);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    pen_down_in = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({pixel_valid_out, busy_out, drop_out, pixel_x_out, pixel_y_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b x=%0d y=%0d, required all 0",
               pixel_valid_out, busy_out, drop_out, pixel_x_out, pixel_y_out);
    end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    pen_down_in = 1'b1;
    pixel_ready_in = 1'b1;
    send(100, 50);
    expect_px(100, 50);
    n_vec++;
    if (pixel_valid_out !== 1'b0 || busy_out !== 1'b1) begin
      n_err++;
      $display("FAIL single_t0: got v=%b busy=%b, required v=0 busy=1", pixel_valid_out, busy_out);
    end
    tick();
    n_vec++;
    if (pixel_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_t1: got v=%b, required 0", pixel_valid_out);
    end
    tick();
    n_vec++;
    if (pixel_valid_out !== 1'b1 || pixel_x_out !== 11'd100 || pixel_y_out !== 10'd50) begin
      n_err++;
      $display("FAIL single_t2: got v=%b (%0d,%0d), required v=1 (100,50)",
               pixel_valid_out, pixel_x_out, pixel_y_out);
    end
    tick();
    n_vec++;
    if (busy_out !== 1'b0 || pixel_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_after: got busy=%b v=%b, required 0 0", busy_out, pixel_valid_out);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0].p !== exp_q[0]) begin
      n_err++;
      $display("FAIL single_px: got %0d pixels, required exactly (100,50)", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_horiz();
    bit ok;
    set_anchor(0, 0);
    send(3, 0);
    for (int i = 0; i <= 3; i++) expect_px(i, 0);
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL horiz_count: got %0d pixels ok=%b, required %0d", obs_q.size(), ok, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i].p !== exp_q[i] || obs_q[i].c !== obs_q[0].c + i) begin
        n_err++;
        $display("FAIL horiz_px%0d: got (%0d,%0d)@%0d, required (%0d,%0d)@%0d", i,
                 obs_q[i].p.x, obs_q[i].p.y, obs_q[i].c, exp_q[i].x, exp_q[i].y, obs_q[0].c + i);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ready_toggle();
    logic        pv;
    logic [10:0] px;
    logic [9:0]  py;
    bit          rdy;
    set_anchor(10, 10);
    send(12, 16);
    expect_px(10, 10); expect_px(10, 11); expect_px(11, 12); expect_px(11, 13);
    expect_px(11, 14); expect_px(12, 15); expect_px(12, 16);
    rdy = 1'b1;
    for (int k = 0; k < 100 && busy_out; k++) begin
      pixel_ready_in = rdy;
      pv = pixel_valid_out; px = pixel_x_out; py = pixel_y_out;
      tick();
      if (pv && !rdy) begin
        n_vec++;
        if (pixel_valid_out !== 1'b1 || pixel_x_out !== px || pixel_y_out !== py) begin
          n_err++;
          $display("FAIL toggle_hold: got v=%b (%0d,%0d), required v=1 (%0d,%0d)",
                   pixel_valid_out, pixel_x_out, pixel_y_out, px, py);
        end
      end
      rdy = ~rdy;
    end
    pixel_ready_in = 1'b1;
    n_vec++;
    if (busy_out || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL toggle_count: got %0d pixels busy=%b, required %0d", obs_q.size(), busy_out, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i].p !== exp_q[i]) begin
        n_err++;
        $display("FAIL toggle_px%0d: got (%0d,%0d), required (%0d,%0d)", i,
                 obs_q[i].p.x, obs_q[i].p.y, exp_q[i].x, exp_q[i].y);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_jump();
    bit ok;
    set_anchor(0, 0);
    send(200, 0);   expect_px(200, 0);             wait_idle(ok);
    send(202, 0);   expect_line(200, 0, 202, 0);   wait_idle(ok);
    send(330, 0);   expect_line(202, 0, 330, 0);   wait_idle(ok);
    send(459, 0);   expect_px(459, 0);             wait_idle(ok);
    send(400, 128); expect_line(459, 0, 400, 128); wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL jump_count: got %0d pixels ok=%b, required %0d", obs_q.size(), ok, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i].p !== exp_q[i]) begin
        n_err++;
        $display("FAIL jump_px%0d: got (%0d,%0d), required (%0d,%0d)", i,
                 obs_q[i].p.x, obs_q[i].p.y, exp_q[i].x, exp_q[i].y);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_drop();
    bit ok;
    set_anchor(0, 0);
    pixel_ready_in = 1'b0;
    send(50, 0);
    expect_line(0, 0, 50, 0);
    repeat (3) tick();
    send(5, 5);
    n_vec++;
    if (drop_out !== 1'b0) begin
      n_err++;
      $display("FAIL drop_first: got %b, required 0", drop_out);
    end
    send(6, 6);
    n_vec++;
    if (drop_out !== 1'b1) begin
      n_err++;
      $display("FAIL drop_pulse: got %b, required 1", drop_out);
    end
    tick();
    n_vec++;
    if (drop_out !== 1'b0) begin
      n_err++;
      $display("FAIL drop_width: got %b, required 0", drop_out);
    end
    expect_line(50, 0, 6, 6);
    pixel_ready_in = 1'b1;
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL drop_count: got %0d pixels ok=%b, required %0d", obs_q.size(), ok, exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i].p !== exp_q[i]) begin
        n_err++;
        $display("FAIL drop_px%0d: got (%0d,%0d), required (%0d,%0d)", i,
                 obs_q[i].p.x, obs_q[i].p.y, exp_q[i].x, exp_q[i].y);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_pen_up();
    bit ok;
    set_anchor(20, 20);
    pen_down_in = 1'b0;
    send(40, 40);
    repeat (2) tick();
    n_vec++;
    if (busy_out !== 1'b0 || pixel_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL penup_ignore: got busy=%b v=%b, required 0 0", busy_out, pixel_valid_out);
    end
    pen_down_in = 1'b1;
    send(30, 30);
    expect_px(30, 30);
    wait_idle(ok);
    n_vec++;
    if (!ok || obs_q.size() != 1 || obs_q[0].p !== exp_q[0]) begin
      n_err++;
      $display("FAIL penup_px: got %0d pixels, required single (30,30)", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    set_anchor(0, 0);
    send(100, 0);
    repeat (5) tick();
    n_vec++;
    if (pixel_valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: got v=%b, required 1", pixel_valid_out);
    end
    rst_in = 1'b0;
    tick();
    n_vec++;
    if (pixel_valid_out !== 1'b0 || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_out: got v=%b busy=%b, required 0 0", pixel_valid_out, busy_out);
    end
    rst_in = 1'b1;
    exp_q.delete(); obs_q.delete();
    repeat (6) tick();
    n_vec++;
    if (obs_q.size() != 0 || busy_out !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_quiet: got %0d pixels busy=%b, required 0 0", obs_q.size(), busy_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_horiz();
    test_ready_toggle();
    test_jump();
    test_drop();
    test_pen_up();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
